// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures arm-to-leading-edge delay and width of one pulse on pulse_in,
// holding the result under a valid/ack handshake. Define PULSE_METER_TIMEOUT_EN to abort long waits.
module pulse_width_meter #(
  parameter int   COUNTER_SIZE   = 16,
  parameter logic IDLE_LEVEL     = 1'b0,
  parameter int   SYNC_STAGES    = 2,
  parameter int   TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    arm,
  input  logic                    pulse_in,
  input  logic                    meas_ack,
  output logic                    busy,
  output logic                    meas_valid,
  output logic [COUNTER_SIZE-1:0] delay_count,
  output logic [COUNTER_SIZE-1:0] width_count,
  output logic                    overflow,
  output logic                    timeout
);

  // state        | meaning
  // S_IDLE       | waiting for arm; last result still visible
  // S_WAIT_EDGE  | counting delay until synchronised idle->active transition
  // S_IN_PULSE   | counting width while the synchronised line stays active
  // S_DONE       | result frozen, meas_valid high until meas_ack
  typedef enum logic [1:0] {S_IDLE, S_WAIT_EDGE, S_IN_PULSE, S_DONE} state_t;

  localparam logic [COUNTER_SIZE-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_SIZE-1:0] CNT_ONE = COUNTER_SIZE'(1);

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    sync, sync_prev, sync_active, lead;
  logic [COUNTER_SIZE-1:0] delay_inc, width_inc, delay_nxt, width_nxt;
  logic                    overflow_nxt, timeout_nxt;
  logic                    delay_hit, width_hit;

  assign sync        = sync_q[SYNC_STAGES-1];
  assign sync_active = (sync != IDLE_LEVEL);
  assign lead        = sync_active && (sync_prev == IDLE_LEVEL);

  // Saturating increments: a counter at its maximum holds its value.
  assign delay_inc = (delay_count == CNT_MAX) ? delay_count : delay_count + CNT_ONE;
  assign width_inc = (width_count == CNT_MAX) ? width_count : width_count + CNT_ONE;

`ifdef PULSE_METER_TIMEOUT_EN
  localparam logic [COUNTER_SIZE-1:0] TIMEOUT_VAL = COUNTER_SIZE'(TIMEOUT_CYCLES);
  assign delay_hit = (delay_inc == TIMEOUT_VAL);
  assign width_hit = (width_inc == TIMEOUT_VAL);
`else
  assign delay_hit = 1'b0;
  assign width_hit = 1'b0;
`endif

  assign busy       = (state != S_IDLE);
  assign meas_valid = (state == S_DONE);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_q      <= {SYNC_STAGES{IDLE_LEVEL}};
      sync_prev   <= IDLE_LEVEL;
      state       <= S_IDLE;
      delay_count <= '0;
      width_count <= '0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      sync_prev   <= sync;
      state       <= state_nxt;
      delay_count <= delay_nxt;
      width_count <= width_nxt;
      overflow    <= overflow_nxt;
      timeout     <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    delay_nxt    = delay_count;
    width_nxt    = width_count;
    overflow_nxt = overflow;
    timeout_nxt  = timeout;
    case (state)
      S_IDLE: begin
        // Results stay readable in IDLE and are only cleared when a new measurement starts.
        if (arm) begin
          state_nxt    = S_WAIT_EDGE;
          delay_nxt    = '0;
          width_nxt    = '0;
          overflow_nxt = 1'b0;
          timeout_nxt  = 1'b0;
        end
      end
      S_WAIT_EDGE: begin
        if (lead) begin
          state_nxt = S_IN_PULSE;
          width_nxt = CNT_ONE;
        end else begin
          delay_nxt = delay_inc;
          if (delay_count == CNT_MAX) overflow_nxt = 1'b1;
          if (delay_hit) begin
            timeout_nxt = 1'b1;
            state_nxt   = S_DONE;
          end
        end
      end
      S_IN_PULSE: begin
        if (sync_active) begin
          width_nxt = width_inc;
          if (width_count == CNT_MAX) overflow_nxt = 1'b1;
          if (width_hit) begin
            timeout_nxt = 1'b1;
            state_nxt   = S_DONE;
          end
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (meas_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: a behavioural model checked every cycle against two instances
// (16-bit and 4-bit counters), plus hand-computed expectations from the measurement timing rules.
`timescale 1ns/1ps
module tb_pulse_width_meter;

  localparam int SYNC = 2;
`ifdef PULSE_METER_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n, arm, pulse_in, meas_ack;
  logic        busy, meas_valid, overflow, timeout;
  logic [15:0] delay_count, width_count;
  logic        arm_s, pulse_s, ack_s;
  logic        busy_s, valid_s, ovf_s, to_s;
  logic [3:0]  delay_s, width_s;

  int checks = 0;
  int failures = 0;
  bit live = 1'b0;

  always #5 clk_in = ~clk_in;

  pulse_width_meter #(.COUNTER_SIZE(16), .IDLE_LEVEL(1'b0), .SYNC_STAGES(2), .TIMEOUT_CYCLES(50)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .arm(arm), .pulse_in(pulse_in), .meas_ack(meas_ack),
    .busy(busy), .meas_valid(meas_valid), .delay_count(delay_count), .width_count(width_count),
    .overflow(overflow), .timeout(timeout));

  pulse_width_meter #(.COUNTER_SIZE(4), .IDLE_LEVEL(1'b0), .SYNC_STAGES(2), .TIMEOUT_CYCLES(0)) dut_s (
    .clk_in(clk_in), .rst_n(rst_n), .arm(arm_s), .pulse_in(pulse_s), .meas_ack(ack_s),
    .busy(busy_s), .meas_valid(valid_s), .delay_count(delay_s), .width_count(width_s),
    .overflow(ovf_s), .timeout(to_s));

  // phase: 0 idle, 1 waiting for edge, 2 in pulse, 3 result held
  typedef struct {
    int          phase;
    int          delay;
    int          width;
    bit          ovf;
    bit          to;
    bit [SYNC:0] hist;  // hist[0] = newest line sample
  } model_t;

  model_t m0, m1;

  function automatic model_t step(input model_t m, input logic rst, input logic a, input logic k,
                                  input logic p, input int maxv, input int tmo);
    model_t n;
    bit seen, prev;
    n = m;
    seen = m.hist[SYNC-1];
    prev = m.hist[SYNC];
    n.hist = {m.hist[SYNC-1:0], p};
    if (!rst) begin
      n.phase = 0; n.delay = 0; n.width = 0; n.ovf = 0; n.to = 0; n.hist = '0;
      return n;
    end
    case (m.phase)
      0: if (a) begin
        n.phase = 1; n.delay = 0; n.width = 0; n.ovf = 0; n.to = 0;
      end
      1: if (seen && !prev) begin
        n.phase = 2; n.width = 1;
      end else begin
        if (m.delay == maxv) n.ovf = 1; else n.delay = m.delay + 1;
        if (tmo > 0 && n.delay == tmo) begin n.to = 1; n.phase = 3; end
      end
      2: if (seen) begin
        if (m.width == maxv) n.ovf = 1; else n.width = m.width + 1;
        if (tmo > 0 && n.width == tmo) begin n.to = 1; n.phase = 3; end
      end else begin
        n.phase = 3;
      end
      3: if (k) n.phase = 0;
      default: n.phase = 0;
    endcase
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: dut=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  always @(posedge clk_in) begin
    m0 <= step(m0, rst_n, arm, meas_ack, pulse_in, 65535, TMO);
    m1 <= step(m1, rst_n, arm_s, ack_s, pulse_s, 15, 0);
    if (!rst_n) live <= 1'b1;
  end

  always @(negedge clk_in) begin
    if (live) begin
      chk("m_busy",    32'(busy),        32'(m0.phase != 0));
      chk("m_valid",   32'(meas_valid),  32'(m0.phase == 3));
      chk("m_delay",   32'(delay_count), 32'(m0.delay));
      chk("m_width",   32'(width_count), 32'(m0.width));
      chk("m_ovf",     32'(overflow),    32'(m0.ovf));
      chk("m_timeout", 32'(timeout),     32'(m0.to));
      chk("s_busy",    32'(busy_s),      32'(m1.phase != 0));
      chk("s_valid",   32'(valid_s),     32'(m1.phase == 3));
      chk("s_delay",   32'(delay_s),     32'(m1.delay));
      chk("s_width",   32'(width_s),     32'(m1.width));
      chk("s_ovf",     32'(ovf_s),       32'(m1.ovf));
      chk("s_timeout", 32'(to_s),        32'(m1.to));
    end
  end

  initial begin
    rst_n = 1'b0; arm = 1'b0; pulse_in = 1'b0; meas_ack = 1'b0;
    arm_s = 1'b0; pulse_s = 1'b0; ack_s = 1'b0;
    tick(2);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_valid", 32'(meas_valid), 0);
    chk("reset_delay", 32'(delay_count), 0);
    chk("reset_width", 32'(width_count), 0);
    chk("reset_ovf", 32'(overflow), 0);
    chk("reset_timeout", 32'(timeout), 0);
    rst_n = 1'b1;
    tick(2);

    // basic: arm at E0, line active after E10 for 5 cycles
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(10); pulse_in = 1'b1;
    tick(5);  pulse_in = 1'b0;
    tick(2);
    chk("basic_valid_e17", 32'(meas_valid), 0);
    tick(1);
    chk("basic_valid_e18", 32'(meas_valid), 1);
    chk("basic_delay", 32'(delay_count), 12);
    chk("basic_width", 32'(width_count), 5);
    chk("basic_ovf", 32'(overflow), 0);

    // hold result without ack while the line toggles and arm is pulsed
    for (int i = 0; i < 20; i++) begin
      pulse_in = i[0];
      arm = (i == 7);
      tick(1);
    end
    pulse_in = 1'b0; arm = 1'b0;
    chk("hold_valid", 32'(meas_valid), 1);
    chk("hold_delay", 32'(delay_count), 12);
    chk("hold_width", 32'(width_count), 5);
    meas_ack = 1'b1; arm = 1'b1; tick(1);
    meas_ack = 1'b0; arm = 1'b0;
    chk("ack_busy", 32'(busy), 0);
    chk("ack_valid", 32'(meas_valid), 0);
    chk("ack_keep_delay", 32'(delay_count), 12);
    tick(3);
    chk("arm_with_ack_not_taken", 32'(busy), 0);

    // line already active at arm; second leading edge after E7, 3 cycles wide
    pulse_in = 1'b1; tick(3);
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(4); pulse_in = 1'b0;
    tick(3); pulse_in = 1'b1;
    tick(3); pulse_in = 1'b0;
    tick(3);
    chk("active_valid", 32'(meas_valid), 1);
    chk("active_delay", 32'(delay_count), 9);
    chk("active_width", 32'(width_count), 3);
    meas_ack = 1'b1; tick(1); meas_ack = 1'b0;

    // reset while in pulse, then a fresh measurement
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(2); pulse_in = 1'b1;
    tick(4);
    chk("pre_reset_busy", 32'(busy), 1);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_delay", 32'(delay_count), 0);
    chk("rst_width", 32'(width_count), 0);
    pulse_in = 1'b0; tick(4);
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(4); pulse_in = 1'b1;
    tick(6); pulse_in = 1'b0;
    tick(3);
    chk("fresh_valid", 32'(meas_valid), 1);
    chk("fresh_delay", 32'(delay_count), 6);
    chk("fresh_width", 32'(width_count), 6);
    meas_ack = 1'b1; tick(1); meas_ack = 1'b0;

    // saturation on the 4-bit instance
    arm_s = 1'b1; tick(1); arm_s = 1'b0;
    tick(1); pulse_s = 1'b1;
    tick(20); pulse_s = 1'b0;
    tick(3);
    chk("sat_valid", 32'(valid_s), 1);
    chk("sat_delay", 32'(delay_s), 3);
    chk("sat_width", 32'(width_s), 15);
    chk("sat_ovf", 32'(ovf_s), 1);
    ack_s = 1'b1; tick(1); ack_s = 1'b0;
    chk("sat_ovf_after_ack", 32'(ovf_s), 1);
    arm_s = 1'b1; tick(1); arm_s = 1'b0;
    chk("rearm_ovf_clear", 32'(ovf_s), 0);
    chk("rearm_width_clear", 32'(width_s), 0);
    tick(20);
    chk("sat_delay_hold", 32'(delay_s), 15);
    chk("sat_delay_ovf", 32'(ovf_s), 1);
    pulse_s = 1'b1; tick(2); pulse_s = 1'b0;
    tick(3);
    chk("sat2_valid", 32'(valid_s), 1);
    chk("sat2_width", 32'(width_s), 2);
    ack_s = 1'b1; tick(1); ack_s = 1'b0;

    // no pulse at all
    arm = 1'b1; tick(1); arm = 1'b0;
`ifdef PULSE_METER_TIMEOUT_EN
    tick(49);
    chk("to_valid_e49", 32'(meas_valid), 0);
    tick(1);
    chk("to_flag", 32'(timeout), 1);
    chk("to_valid", 32'(meas_valid), 1);
    chk("to_delay", 32'(delay_count), 50);
    meas_ack = 1'b1; tick(1); meas_ack = 1'b0;
`else
    tick(200);
    chk("no_to_busy_e200", 32'(busy), 1);
    chk("no_to_flag", 32'(timeout), 0);
    chk("no_to_delay", 32'(delay_count), 200);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    chk("no_to_reset_exit", 32'(busy), 0);
`endif
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Downstream capture stage for the test-board pulse generators: it measures the leading-edge delay and the width of one pulse on a DUT-facing line. Delay is measured from a software/FSM `arm` strobe. The line is synchronised into `clk_in`, and the result is held under a valid/ack handshake until the readout logic collects it. One measurement per arm.

## Interface
- `COUNTER_SIZE`, 16: width of delay and width counters.
- `IDLE_LEVEL`, 0: inactive level of `pulse_in`; the active level is `~IDLE_LEVEL`.
- `SYNC_STAGES`, 2: synchroniser flops on `pulse_in`, minimum 2.
- `TIMEOUT_CYCLES`, 1000: abort limit. Used only with `PULSE_METER_TIMEOUT_EN`; must be ≤ 2^COUNTER_SIZE−1.

Ports:
- `clk_in`  in  1  single clock.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `arm`  in  1  start a measurement; sampled only in IDLE.
- `pulse_in`  in  1  asynchronous pulse line under measurement.
- `meas_ack`  in  1  consumer accepts the result; sampled only in DONE.
- `busy`  out  1  state ≠ IDLE.
- `meas_valid`  out  1  result valid; high exactly in DONE.
- `delay_count`  out  COUNTER_SIZE  cycles from arm to detected leading edge.
- `width_count`  out  COUNTER_SIZE  detected pulse width in cycles.
- `overflow`  out  1  a counter saturated during this measurement.
- `timeout`  out  1  measurement aborted by timeout.

## Operation
- Synchroniser:
  - `SYNC_STAGES` flops. The last stage is `sync`; a further flop holds `sync_prev`.
  - All are reset to `IDLE_LEVEL`.
  - Leading edge `lead` = `sync`==active && `sync_prev`==idle.
- FSM states: IDLE, WAIT_EDGE, IN_PULSE, DONE.
- IDLE:
  - `arm`=1 → WAIT_EDGE.
  - `delay_count`, `width_count`, `overflow` and `timeout` are cleared to 0.
- WAIT_EDGE:
  - If `lead` → IN_PULSE, with `width_count`←1.
  - Otherwise `delay_count`+1.
  - A line already active at arm is not a leading edge; the block waits for the next idle→active transition.
- IN_PULSE:
  - `sync` active → `width_count`+1.
  - `sync` idle → DONE.
- DONE:
  - `meas_valid`=1 and all result outputs are frozen.
  - `meas_ack`=1 → IDLE; outputs keep their values until the next arm.
- Arithmetic:
  - Both counters saturate at 2^COUNTER_SIZE−1 and never wrap.
  - Any attempted increment past saturation sets `overflow`, which stays set until the next arm.
  - On saturation the FSM continues normally.
- Ignored inputs:
  - `arm` outside IDLE is ignored; it is not queued.
  - `meas_ack` outside DONE is ignored.
  - `arm` and `meas_ack` high together in DONE: ack is taken and the block goes to IDLE. The arm is not taken; arm again in IDLE.
- Reset (`rst_n`=0 at a clock edge, any state):
  - State → IDLE.
  - All outputs → 0.
  - Synchroniser → `IDLE_LEVEL`.
  - An in-flight measurement is discarded.

## Timing
- Reference frame:
  - Arm is sampled at edge E0, entering WAIT_EDGE with `delay_count`=0.
  - `pulse_in` goes active just after edge Ek (k≥1) and stays active for W≥1 full cycles.
- Results: `delay_count` = k + SYNC_STAGES and `width_count` = W.
- Event edges:
  - `lead` is seen at edge E(k+SYNC_STAGES+1).
  - DONE is entered at edge E(k+W+SYNC_STAGES+1).
  - `meas_valid` rises in the cycle after that edge.
- Handshake: `meas_ack` is sampled at a DONE edge. `meas_valid` drops and `busy` drops after that edge.
- Back-to-back: the earliest re-arm is the cycle after the ack edge.
- Pulse limits:
  - Pulses shorter than one clock may be missed; this is not flagged.
  - Idle gaps of one cycle inside IN_PULSE end the measurement.

## Configuration
- `PULSE_METER_TIMEOUT_EN` defined:
  - In WAIT_EDGE, `delay_count` reaching `TIMEOUT_CYCLES` sets `timeout`=1 and goes to DONE.
  - In IN_PULSE, `width_count` reaching `TIMEOUT_CYCLES` does the same.
  - The counter holds `TIMEOUT_CYCLES`.
- Not defined:
  - No timeout logic; `timeout` is tied to 0.
  - WAIT_EDGE and IN_PULSE can last indefinitely; only reset exits them.

## Test plan
- Basic measurement: SYNC_STAGES=2. Arm at E0, `pulse_in` 0→1 after E10, held 5 cycles → `delay_count`=12, `width_count`=5, `meas_valid` rises after E18, `overflow`=0.
- Handshake hold: keep `meas_ack`=0 for 20 cycles and toggle `pulse_in` → outputs and `meas_valid` unchanged. Ack at one edge → `busy`=0 the next cycle; `arm` during DONE is ignored.
- Already-active line: `pulse_in` high at arm for 4 cycles, drops, then a 3-cycle pulse → `width_count`=3. The delay counts from arm to the second leading edge.
- Saturation: COUNTER_SIZE=4, 20-cycle pulse → `width_count`=15, `overflow`=1. The following arm clears `overflow` to 0.
- Reset mid-operation: `rst_n`=0 for one edge during IN_PULSE → next cycle all outputs 0 and state IDLE. A fresh arm measures correctly.
- Timeout: with `PULSE_METER_TIMEOUT_EN`, TIMEOUT_CYCLES=50, no pulse → after E50 `timeout`=1, `meas_valid`=1, `delay_count`=50. Without the macro → still `busy` at E200.
